// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// No logic here; imported by the queue, the interface users and the top.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL
  } state_e;

  localparam int PARCEL_W   = 16;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/fetch_ctl_if.sv
// Instruction memory port: request held with a stable address until ack; ack may arrive in the request cycle.
// master = fetch sequencer, slave = instruction memory.
interface fetch_ctl_if #(
  parameter int RV = 32
);

  logic          mem_req;
  logic [RV-1:0] mem_addr;
  logic          mem_ack;
  logic [RV-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/fetch_queue.sv
// Halfword FIFO, 0/1/2 parcels pushed and 1 popped per cycle; head is register-backed (zero-latency read).
// No internal backpressure: the caller only pushes when count leaves room for two parcels.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [1:0]          push_n,
  input  logic [PARCEL_W-1:0] push_p0,
  input  logic [PARCEL_W-1:0] push_p1,
  input  logic                pop,
  output logic [CW-1:0]       count,
  output logic [PARCEL_W-1:0] head_dat,
  output logic                head_vld
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [PARCEL_W-1:0] mem [DEPTH];
  logic [AW-1:0]       head;
  logic [AW-1:0]       tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Leave head where it is so ins keeps showing the old head value.
      tail  <= head;
      count <= '0;
    end else begin
      if (push_n != 2'd0) begin
        mem[tail] <= push_p0;
      end
      if (push_n == 2'd2) begin
        mem[tail + PTR_ONE] <= push_p1;
      end
      tail <= tail + AW'(push_n);
      if (pop) begin
        head <= head + PTR_ONE;
      end
      count <= count + CW'(push_n) - CW'(pop);
    end
  end

  assign head_dat = mem[head];
  assign head_vld = (count != '0);

endmodule

// File: rtl/fetch_ctl.sv
// Fetch sequencer: words from the memory port become 16-bit parcels, one per cycle to decode; redirect->parcel in 2 cycles.
// stall holds the queue head; fetching pauses while fewer than two parcel slots are free.
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter int          RV       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect,
  input  logic [RV-1:0]       redirect_pc,
  input  logic                stall,
  output logic [PARCEL_W-1:0] ins,
  output logic                rdone,
  output logic [RV-1:0]       pc,
  fetch_ctl_if.master         mem
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [RV-1:0] HALF_MASK = ~RV'(1);
  localparam logic [RV-1:0] WORD_MASK = ~RV'(WORD_BYTES - 1);
  localparam logic [RV-1:0] RST_PC    = RV'(RESET_PC);

  state_e              state;
  state_e              state_nxt;
  logic [RV-1:0]       faddr;
  logic [RV-1:0]       kill_addr;
  logic                skip_low;
  logic                space;
  logic                issue;
  logic                req;
  logic                keep;
  logic [1:0]          push_n;
  logic [PARCEL_W-1:0] push_p0;
  logic [CW-1:0]       count;
  logic                head_vld;

  assign space = (int'(count) + 2) <= DEPTH;

  // IDLE issues combinationally so a fresh request goes out the cycle after a flush.
  always_comb begin
    state_nxt = state;
    issue     = (state == IDLE) && space && !redirect;
    req       = !reset && (issue || state == FETCH || state == KILL);
    case (state)
      IDLE:    if (issue && !mem.mem_ack) state_nxt = FETCH;
      FETCH: begin
        if (mem.mem_ack)   state_nxt = IDLE;
        else if (redirect) state_nxt = KILL;
      end
      KILL:    if (mem.mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign keep    = req && mem.mem_ack && (state != KILL) && !redirect;
  assign push_n  = !keep ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
  assign push_p0 = skip_low ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  assign mem.mem_req  = req;
  assign mem.mem_addr = !req ? '0 : ((state == KILL) ? kill_addr : faddr);

  assign rdone = head_vld && !stall && !redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RST_PC & HALF_MASK;
      faddr     <= RST_PC & WORD_MASK;
      skip_low  <= RST_PC[1];
      kill_addr <= '0;
    end else begin
      state <= state_nxt;
      // Tracks the outstanding address so a kill keeps presenting it after faddr retargets.
      if (state == FETCH) begin
        kill_addr <= faddr;
      end
      if (redirect) begin
        pc       <= redirect_pc & HALF_MASK;
        faddr    <= redirect_pc & WORD_MASK;
        skip_low <= redirect_pc[1];
      end else begin
        if (keep) begin
          faddr    <= faddr + RV'(WORD_BYTES);
          skip_low <= 1'b0;
        end
        if (rdone) begin
          pc <= pc + RV'(2);
        end
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push_n   (push_n),
    .push_p0  (push_p0),
    .push_p1  (mem.mem_rdata[31:16]),
    .pop      (rdone),
    .count    (count),
    .head_dat (ins),
    .head_vld (head_vld)
  );

endmodule

// File: tb/tb_fetch_ctl.sv
// Bench for fetch_ctl: directed scenarios plus random stall/redirect/wait traffic against a PC-stream scoreboard.
module tb_fetch_ctl;
  import fetch_pkg::*;

  localparam int          RV       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                clk = 1'b0;
  logic                reset;
  logic                redirect;
  logic [RV-1:0]       redirect_pc;
  logic                stall;
  logic [PARCEL_W-1:0] ins;
  logic                rdone;
  logic [RV-1:0]       pc;

  fetch_ctl_if #(.RV(RV)) m ();

  fetch_ctl #(.RV(RV), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .ins         (ins),
    .rdone       (rdone),
    .pc          (pc),
    .mem         (m)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;
  int          fixed_wait = 0;
  int          max_wait = 0;
  bit          pend = 0;
  int          wcnt = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  int          delivered = 0;

  // Memory image: every halfword is a function of its own address.
  function automatic logic [15:0] parcel(input logic [31:0] p);
    case (p)
      32'd0:   return 16'h0111;
      32'd2:   return 16'h2222;
      32'd4:   return 16'h0333;
      32'd6:   return 16'h4444;
      default: return p[15:0] ^ p[31:16] ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {parcel(a + 32'd2), parcel(a)};
  endfunction

  // One clock: drive at negedge, answer memory, then check the in-order PC stream.
  task automatic cycle(input logic rst, input logic rd, input logic [31:0] rpc, input logic st);
    @(negedge clk);
    reset = rst; redirect = rd; redirect_pc = rpc; stall = st;
    #1;
    if (reset || !m.mem_req) begin
      pend = 0; m.mem_ack = 1'b0; m.mem_rdata = $urandom;
    end else begin
      if (!pend) begin
        pend = 1;
        wcnt = (fixed_wait >= 0) ? fixed_wait : $urandom_range(max_wait, 0);
      end
      if (wcnt == 0) begin
        m.mem_ack = 1'b1; m.mem_rdata = word(m.mem_addr); pend = 0;
      end else begin
        m.mem_ack = 1'b0; m.mem_rdata = $urandom; wcnt--;
      end
    end
    #1;
    if (m.mem_req === 1'b1) begin
      total++;
      if (m.mem_addr[1:0] !== 2'b00) begin
        bad++; $display("FAIL addr_align: got %h want low bits 00", m.mem_addr);
      end
    end
    if (prev_wait && m.mem_req === 1'b1 && !reset) begin
      total++;
      if (m.mem_addr !== prev_addr) begin
        bad++; $display("FAIL addr_hold: got %h want %h", m.mem_addr, prev_addr);
      end
    end
    prev_wait = (m.mem_req === 1'b1) && (m.mem_ack !== 1'b1);
    prev_addr = m.mem_addr;
    if (rst) begin
      exp_pc = RESET_PC & ~32'd1;
    end else if (rd) begin
      total++;
      if (rdone !== 1'b0) begin
        bad++; $display("FAIL redirect_rdone: got %b want 0", rdone);
      end
      exp_pc = rpc & ~32'd1;
    end else if (rdone === 1'b1) begin
      total += 2;
      if (pc !== exp_pc) begin
        bad++; $display("FAIL stream_pc: got %h want %h", pc, exp_pc);
      end
      if (ins !== parcel(exp_pc)) begin
        bad++; $display("FAIL stream_ins: got %h want %h (pc %h)", ins, parcel(exp_pc), exp_pc);
      end
      exp_pc += 32'd2;
      delivered++;
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic st);
    cycle(1'b0, rd, rpc, st);
  endtask

  task automatic expect_req(input string name, input logic [31:0] addr);
    total++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== addr) begin
      bad++; $display("FAIL %s: got req=%b addr=%h want req=1 addr=%h", name, m.mem_req, m.mem_addr, addr);
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] epc, input logic [15:0] eins);
    total++;
    if (rdone !== 1'b1 || pc !== epc || ins !== eins) begin
      bad++; $display("FAIL %s: got rdone=%b pc=%h ins=%h want rdone=1 pc=%h ins=%h", name, rdone, pc, ins, epc, eins);
    end
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    total += 5;
    if (m.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", m.mem_req); end
    if (m.mem_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", m.mem_addr); end
    if (rdone !== 1'b0) begin bad++; $display("FAIL rst_rdone: got %b want 0", rdone); end
    if (ins !== '0) begin bad++; $display("FAIL rst_ins: got %h want 0", ins); end
    if (pc !== RESET_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); end
  endtask

  task automatic test_startup;
    logic [15:0] tbl [4];
    tbl = '{16'h0111, 16'h2222, 16'h0333, 16'h4444};
    fixed_wait = 0;
    step(1'b0, '0, 1'b0);
    expect_req("start_req", 32'h0);
    total++;
    if (rdone !== 1'b0) begin bad++; $display("FAIL start_rdone0: got %b want 0", rdone); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0);
      expect_out("start_stream", 32'(2 * i), tbl[i]);
    end
  endtask

  task automatic test_stall;
    logic [31:0] hold_pc;
    logic [15:0] hold_ins;
    step(1'b0, '0, 1'b1);
    hold_pc = pc; hold_ins = ins;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, '0, 1'b1);
      total++;
      if (pc !== hold_pc || ins !== hold_ins || rdone !== 1'b0) begin
        bad++; $display("FAIL stall_hold: got pc=%h ins=%h rdone=%b want pc=%h ins=%h rdone=0", pc, ins, rdone, hold_pc, hold_ins);
      end
    end
    total++;
    if (m.mem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq: got %b want 0", m.mem_req); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0);
      total++;
      if (rdone !== 1'b1) begin bad++; $display("FAIL stall_release: got rdone=%b want 1", rdone); end
    end
  endtask

  task automatic test_redirect_full;
    repeat (6) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h102, 1'b1);
    total++;
    if (m.mem_req !== 1'b0) begin bad++; $display("FAIL redir_req0: got %b want 0", m.mem_req); end
    step(1'b0, '0, 1'b0);
    expect_req("redir_req", 32'h100);
    step(1'b0, '0, 1'b0);
    expect_out("redir_first", 32'h102, 16'h5B58);
    step(1'b0, '0, 1'b0);
    expect_out("redir_second", 32'h104, parcel(32'h104));
  endtask

  task automatic test_kill;
    fixed_wait = 3;
    step(1'b1, 32'h200, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_req("kill_issue", 32'h200);
    step(1'b1, 32'h300, 1'b0);
    expect_req("kill_fetch_hold", 32'h200);
    step(1'b1, 32'h400, 1'b0);
    expect_req("kill_hold", 32'h200);
    fixed_wait = 0;
    step(1'b0, '0, 1'b0);
    expect_req("kill_ack", 32'h200);
    step(1'b0, '0, 1'b0);
    expect_req("kill_refetch", 32'h400);
    step(1'b0, '0, 1'b0);
    expect_out("kill_first", 32'h400, 16'h5E5A);
  endtask

  task automatic test_same_cycle;
    fixed_wait = 1;
    step(1'b1, 32'h500, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_req("same_issue", 32'h500);
    fixed_wait = 0;
    step(1'b1, 32'h600, 1'b1);
    total++;
    if (m.mem_ack !== 1'b1 || rdone !== 1'b0) begin
      bad++; $display("FAIL same_cycle: got ack=%b rdone=%b want ack=1 rdone=0", m.mem_ack, rdone);
    end
    step(1'b0, '0, 1'b0);
    expect_req("same_refetch", 32'h600);
    step(1'b0, '0, 1'b0);
    expect_out("same_first", 32'h600, 16'h5C5A);
  endtask

  task automatic test_wrap;
    fixed_wait = 0;
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_req("wrap_req", 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b0);
    expect_out("wrap_p0", 32'hFFFF_FFFC, parcel(32'hFFFF_FFFC));
    expect_req("wrap_addr0", 32'h0);
    step(1'b0, '0, 1'b0);
    expect_out("wrap_p1", 32'hFFFF_FFFE, parcel(32'hFFFF_FFFE));
    step(1'b0, '0, 1'b0);
    expect_out("wrap_p2", 32'h0, 16'h0111);
  endtask

  task automatic test_reset_mid;
    fixed_wait = 5;
    step(1'b1, 32'h700, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_req("midrst_pending", 32'h700);
    cycle(1'b1, 1'b0, '0, 1'b0);
    total++;
    if (m.mem_req !== 1'b0 || pc !== RESET_PC) begin
      bad++; $display("FAIL midrst_drop: got req=%b pc=%h want req=0 pc=%h", m.mem_req, pc, RESET_PC);
    end
    fixed_wait = 0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_out("midrst_restart", 32'h0, 16'h0111);
  endtask

  task automatic test_random;
    int start;
    start = delivered;
    fixed_wait = -1;
    max_wait = 3;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99, 0) < 4, $urandom, $urandom_range(99, 0) < 30);
    end
    fixed_wait = 0;
    repeat (10) step(1'b0, '0, 1'b0);
    total++;
    if (delivered - start < 300) begin
      bad++; $display("FAIL random_progress: got %0d parcels want at least 300", delivered - start);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    m.mem_ack = 1'b0; m.mem_rdata = '0;
    exp_pc = RESET_PC;
    test_reset;
    test_startup;
    test_stall;
    test_redirect_full;
    test_kill;
    test_same_cycle;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_ctl.md
Name: fetch_ctl

Overview:
- Instruction fetch sequencer in front of `decode`. Fetches RV-wide aligned words from the instruction memory port and splits them into 16-bit parcels held in a small halfword queue.
- Presents one parcel per cycle to `decode` on ins/rdone, with the parcel's PC.
- Handles branch/jump redirect, including a redirect target in the upper half of a word, and kills in-flight fetches on redirect.

Parameters:
- RV, 32, register/address width (only 32 is supported).
- DEPTH, 4, halfword queue depth; must be a power of 2 and at least 4.
- RESET_PC, 32'h0000_0000, PC of the first parcel after reset; bit 0 is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- redirect  in  1  flush and restart at redirect_pc (from branch/jump resolution)
- redirect_pc  in  RV  new PC; bit 0 is ignored
- stall  in  1  downstream cannot accept a parcel this cycle
- ins  out  16  parcel at queue head; feeds decode.ins
- rdone  out  1  ins is valid and consumed this cycle; feeds decode.rdone
- pc  out  RV  PC of the parcel on ins
- mem_req  out  1  fetch request
- mem_addr  out  RV  word address, bits [1:0] = 0
- mem_ack  in  1  request complete; mem_rdata is valid this cycle
- mem_rdata  in  RV  fetched word; little-endian, parcel 0 = [15:0]

Behaviour:
- Reset (asynchronous): state = IDLE, queue empty (count = 0), pc = RESET_PC, fetch address = RESET_PC & ~3, skip_low = RESET_PC[1], rdone = 0, mem_req = 0, mem_addr = 0, ins = 0. Reset asserted mid-fetch abandons the request; a late mem_ack after reset is ignored (IDLE).
- State machine:
  - IDLE → FETCH when (count + 2) ≤ DEPTH and !redirect.
  - FETCH holds mem_req = 1 with mem_addr stable until mem_ack.
  - FETCH, mem_ack, no redirect → IDLE, or directly reissue to the next word if space still allows (back-to-back fetch, no bubble).
  - FETCH, redirect without mem_ack → KILL.
  - KILL keeps mem_req = 1 at the old address until mem_ack, discards the data, then → IDLE.
  - FETCH or KILL, redirect and mem_ack in the same cycle → data discarded, → IDLE.
- Push on a kept mem_ack:
  - Write parcel 0 then parcel 1 at the tail, unless skip_low, in which case write parcel 1 only and clear skip_low.
  - Fetch address += 4, wrapping modulo 2^RV.
- Pop: rdone = (count ≠ 0) & !stall & !redirect. On rdone, head advances and pc += 2, wrapping modulo 2^RV.
- Push and pop in the same cycle are legal: count' = count + pushed − popped. The space check uses registered count, so it is conservative and can never overflow.
- Head/tail pointers are log2(DEPTH) bits and wrap naturally.
- Redirect (highest priority):
  - Same cycle: rdone = 0.
  - Next edge: queue flushed (count = 0), pc = redirect_pc & ~1, fetch address = redirect_pc & ~3, skip_low = redirect_pc[1].
  - redirect with stall: redirect wins.
  - A second redirect while in KILL updates the target only; the kill remains in effect.
- Latency with zero-wait memory (ack in the request cycle):
  - redirect in cycle N → mem_req in N+1 → rdone with the target parcel in N+2.
  - Steady-state throughput is 1 parcel/cycle.
- ins and pc are registered-queue outputs (no combinational path from mem_rdata). They are don't-care when rdone = 0 but must hold the head value.
- mem_req never asserts while count + 2 > DEPTH, except during KILL completion.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, FETCH, KILL}
  - PARCEL_W = 16
  - WORD_BYTES = 4
- Sub-module fetch_queue: halfword FIFO with a 0/1/2-parcel push port and a 1-parcel pop port. It exposes count, head data and head-valid. fetch_ctl owns the state machine and the pc/fetch-address/skip_low registers.

Test Plan:
- Reset release with RESET_PC = 0, zero-wait memory returning 0x22220111 at 0 and 0x44440333 at 4 → rdone sequence ins = 0x0111 (pc 0), 0x2222 (pc 2), 0x0333 (pc 4), 0x4444 (pc 6), back-to-back with no bubble.
- redirect with redirect_pc = 0x102 while the queue is full → next edge flush; fetch at 0x100; first rdone gives the upper half of word 0x100 with pc = 0x102, 2 cycles after redirect.
- redirect while FETCH is waiting on a 3-cycle ack → mem_addr held until ack, data not queued, then a new request to the target; no stale parcel ever appears on rdone.
- stall held for 10 cycles → queue fills to DEPTH; mem_req stays low once count + 2 > DEPTH; ins/pc stable; release gives in-order delivery with no loss or duplicates.
- redirect, mem_ack and stall asserted in the same cycle → ack data dropped, rdone = 0, then fetch at the redirect target.
- PC wrap: redirect to 0xFFFF_FFFC → parcels at pc 0xFFFF_FFFC and 0xFFFF_FFFE, then fetch address 0x0000_0000, pc 0x0; reset asserted mid-FETCH drops mem_req immediately.
